// File: rtl/clk_div_switch_if.sv
// Channel-select request handshake between a requester (master) and clk_div_switch (slave).
interface clk_div_switch_if #(
    parameter int CLK_NUM = 3
);
    localparam int SEL_W = $clog2(CLK_NUM);

    logic [SEL_W-1:0] sel;
    logic             sel_vld;
    logic             sel_rdy;

    modport master (output sel, output sel_vld, input sel_rdy);
    modport slave  (input sel, input sel_vld, output sel_rdy);
endinterface

// File: rtl/clk_div_switch.sv
// Programmable clock divider selecting one of CLK_NUM half-period channels;
// channel changes happen only at the end of a low phase, followed by a fixed low gap.
module clk_div_switch #(
    parameter int CLK_NUM = 3,
    parameter int CNT_W   = 4,
    parameter int GAP_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CLK_NUM*CNT_W-1:0]   div_cfg,
    clk_div_switch_if.slave            req,
    output logic                       clk_out,
    output logic                       clk_en,
    output logic [$clog2(CLK_NUM)-1:0] cur_sel,
    output logic                       sw_done
);
    localparam int SEL_W = $clog2(CLK_NUM);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic             clk_out_r, clk_out_nxt_s;
    logic             clk_en_r, clk_en_nxt_s;
    logic             sw_done_r, sw_done_nxt_s;
    logic             sel_rdy_r, sel_rdy_nxt_s;
    logic             h_vld_r;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [CNT_W-1:0] h_cur_r, h_cur_nxt_s, h_use_s;
    logic [GAP_W-1:0] gap_cnt_r, gap_cnt_nxt_s;
    logic [SEL_W-1:0] cur_sel_r, cur_sel_nxt_s;
    logic [SEL_W-1:0] pend_sel_r, pend_sel_nxt_s;
    logic [SEL_W-1:0] req_map_s;
    logic             phase_end_s, switch_req_s, hold_low_s, gap_end_s;

    // A zero field is treated as a half-period of one cycle.
    function automatic logic [CNT_W-1:0] half_of(input logic [CLK_NUM*CNT_W-1:0] cfg,
                                                 input logic [SEL_W-1:0] ch);
        logic [CNT_W-1:0] fld;
        fld = cfg[int'(ch)*CNT_W +: CNT_W];
        if (fld == {CNT_W{1'b0}}) begin
            half_of = CNT_W'(1);
        end else begin
            half_of = fld;
        end
    endfunction

    function automatic logic [SEL_W-1:0] map_sel(input logic [SEL_W-1:0] s);
        if (int'(s) >= CLK_NUM) begin
            map_sel = {SEL_W{1'b0}};
        end else begin
            map_sel = s;
        end
    endfunction

    // Until the first edge after reset, the live channel-0 field stands in for h_cur.
    assign h_use_s      = h_vld_r ? h_cur_r : half_of(div_cfg, cur_sel_r);
    assign phase_end_s  = (cnt_r == (h_use_s - CNT_W'(1)));
    assign req_map_s    = map_sel(req.sel);
    assign switch_req_s = (state_r == ST_RUN) && sel_rdy_r && req.sel_vld && (req_map_s != cur_sel_r);
    assign hold_low_s   = (state_r == ST_WAIT) && !clk_out_r && phase_end_s;
    assign gap_end_s    = (state_r == ST_GAP) && (gap_cnt_r == GAP_W'(GAP_CYC - 1));

    // Next-state logic for the switch controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (switch_req_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (hold_low_s) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_GAP: begin
                if (gap_end_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Next values of the phase counter, divided clock, channel registers and pulses.
    always_comb begin
        clk_out_nxt_s  = clk_out_r;
        clk_en_nxt_s   = 1'b0;
        sw_done_nxt_s  = 1'b0;
        cnt_nxt_s      = cnt_r;
        h_cur_nxt_s    = h_cur_r;
        gap_cnt_nxt_s  = gap_cnt_r;
        cur_sel_nxt_s  = cur_sel_r;
        pend_sel_nxt_s = pend_sel_r;
        sel_rdy_nxt_s  = (state_nxt_s == ST_RUN);
        if (state_r == ST_GAP) begin
            if (gap_end_s) begin
                clk_out_nxt_s = 1'b1;
                clk_en_nxt_s  = 1'b1;
                sw_done_nxt_s = 1'b1;
                cnt_nxt_s     = {CNT_W{1'b0}};
                gap_cnt_nxt_s = {GAP_W{1'b0}};
                cur_sel_nxt_s = pend_sel_r;
                h_cur_nxt_s   = half_of(div_cfg, pend_sel_r);
            end else begin
                gap_cnt_nxt_s = gap_cnt_r + GAP_W'(1);
            end
        end else if (hold_low_s) begin
            // Suppress the rise: the low phase runs on into the gap.
            cnt_nxt_s     = {CNT_W{1'b0}};
            gap_cnt_nxt_s = {GAP_W{1'b0}};
        end else if (phase_end_s) begin
            clk_out_nxt_s = !clk_out_r;
            clk_en_nxt_s  = !clk_out_r;
            cnt_nxt_s     = {CNT_W{1'b0}};
            h_cur_nxt_s   = half_of(div_cfg, cur_sel_r);
        end else begin
            cnt_nxt_s   = cnt_r + CNT_W'(1);
            h_cur_nxt_s = h_use_s;
        end
        if (switch_req_s) begin
            pend_sel_nxt_s = req_map_s;
        end else begin
            pend_sel_nxt_s = pend_sel_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_out_r  <= 1'b0;
            clk_en_r   <= 1'b0;
            sw_done_r  <= 1'b0;
            sel_rdy_r  <= 1'b1;
            h_vld_r    <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            h_cur_r    <= CNT_W'(1);
            gap_cnt_r  <= {GAP_W{1'b0}};
            cur_sel_r  <= {SEL_W{1'b0}};
            pend_sel_r <= {SEL_W{1'b0}};
        end else begin
            clk_out_r  <= clk_out_nxt_s;
            clk_en_r   <= clk_en_nxt_s;
            sw_done_r  <= sw_done_nxt_s;
            sel_rdy_r  <= sel_rdy_nxt_s;
            h_vld_r    <= 1'b1;
            cnt_r      <= cnt_nxt_s;
            h_cur_r    <= h_cur_nxt_s;
            gap_cnt_r  <= gap_cnt_nxt_s;
            cur_sel_r  <= cur_sel_nxt_s;
            pend_sel_r <= pend_sel_nxt_s;
        end
    end

    assign clk_out     = clk_out_r;
    assign clk_en      = clk_en_r;
    assign sw_done     = sw_done_r;
    assign cur_sel     = cur_sel_r;
    assign req.sel_rdy = sel_rdy_r;

endmodule

// File: tb/tb_clk_div_switch.sv
// Self-checking bench for clk_div_switch: a queue of future output samples per phase
// predicts every cycle, with literal trace checks pinning the key scenarios.
module tb_clk_div_switch;
    localparam int CLK_NUM = 3;
    localparam int CNT_W   = 4;
    localparam int GAP_CYC = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] div_cfg;
    logic        clk_out, clk_en, sw_done;
    logic [1:0]  cur_sel;
    int          errors = 0;
    int          checks = 0;

    clk_div_switch_if #(.CLK_NUM(CLK_NUM)) ifc ();

    clk_div_switch #(.CLK_NUM(CLK_NUM), .CNT_W(CNT_W), .GAP_CYC(GAP_CYC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_cfg (div_cfg),
        .req     (ifc),
        .clk_out (clk_out),
        .clk_en  (clk_en),
        .cur_sel (cur_sel),
        .sw_done (sw_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic lvl;
        logic en;
        logic done;
    } ent_t;

    // Model: q holds expected samples for the current and upcoming cycles.
    ent_t        q[$];
    int          m_cur, m_pend;
    bit          m_pend_v, m_rdy, m_last, m_gap, m_fresh;
    logic [31:0] tr_out, tr_en, tr_done;

    function automatic int h_of(input logic [11:0] cfg, input int ch);
        int f;
        f = int'((cfg >> (ch * CNT_W)) & 12'hF);
        return (f == 0) ? 1 : f;
    endfunction

    task automatic push_run(input logic lvl, input int n, input logic done);
        logic fl;
        for (int i = 0; i < n; i++) begin
            fl = (i == 0);
            q.push_back(ent_t'{lvl, fl & lvl, fl & done});
        end
    endtask

    task automatic model_reset();
        q.delete();
        q.push_back(ent_t'{1'b0, 1'b0, 1'b0});
        m_cur = 0; m_pend = 0; m_pend_v = 1'b0; m_rdy = 1'b1;
        m_last = 1'b0; m_gap = 1'b0; m_fresh = 1'b1;
    endtask

    task automatic model_step();
        bit   rdy_before;
        int   mapped;
        ent_t tmp;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rdy_before = m_rdy;
        if (m_fresh) begin
            push_run(1'b0, h_of(div_cfg, 0) - 1, 1'b0);
            m_fresh = 1'b0;
        end
        tmp = q.pop_front();
        if (q.size() == 0) begin
            if (m_gap) begin
                m_gap = 1'b0; m_cur = m_pend; m_pend_v = 1'b0; m_rdy = 1'b1; m_last = 1'b1;
                push_run(1'b1, h_of(div_cfg, m_cur), 1'b1);
            end else if (!m_last && m_pend_v) begin
                m_gap = 1'b1;
                push_run(1'b0, GAP_CYC, 1'b0);
            end else begin
                m_last = !m_last;
                push_run(m_last, h_of(div_cfg, m_cur), 1'b0);
            end
        end
        if (rdy_before && ifc.sel_vld) begin
            mapped = (int'(ifc.sel) >= CLK_NUM) ? 0 : int'(ifc.sel);
            if (mapped != m_cur) begin
                m_pend = mapped; m_pend_v = 1'b1; m_rdy = 1'b0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        ent_t e;
        e = q[0];
        chk("clk_out", 32'(clk_out), 32'(e.lvl));
        chk("clk_en", 32'(clk_en), 32'(e.en));
        chk("sw_done", 32'(sw_done), 32'(e.done));
        chk("cur_sel", 32'(cur_sel), 32'(m_cur));
        chk("sel_rdy", 32'(ifc.sel_rdy), 32'(m_rdy));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
        tr_out  = {tr_out[30:0], clk_out};
        tr_en   = {tr_en[30:0], clk_en};
        tr_done = {tr_done[30:0], sw_done};
    endtask

    task automatic step_until_done(input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            step();
            seen = sw_done;
        end
        chk("sw_done_reached", 32'(seen), 32'd1);
    endtask

    initial begin
        bit seen;
        ifc.sel = 2'd0; ifc.sel_vld = 1'b0; div_cfg = 12'h321;
        tr_out = 32'd0; tr_en = 32'd0; tr_done = 32'd0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        compare_all();
        step(); step();
        rst_n = 1'b1;

        // ch0 (H=1) free-running after reset
        repeat (6) step();
        chk("ch0_clk_out_trace", 32'(tr_out[5:0]), 32'b101010);
        chk("ch0_clk_en_trace", 32'(tr_en[5:0]), 32'b101010);

        // switch ch0 -> ch2, request seen in the last low cycle
        ifc.sel = 2'd2; ifc.sel_vld = 1'b1;
        step();
        ifc.sel_vld = 1'b0;
        repeat (7) step();
        chk("sw02_clk_out_trace", 32'(tr_out[7:0]), 32'b10001110);
        chk("sw02_sw_done_trace", 32'(tr_done[7:0]), 32'b00001000);
        chk("sw02_cur_sel", 32'(cur_sel), 32'd2);

        // same-channel request is a no-op; out-of-range request maps to ch0
        ifc.sel = 2'd2; ifc.sel_vld = 1'b1;
        step();
        ifc.sel_vld = 1'b0;
        chk("noop_sel_rdy", 32'(ifc.sel_rdy), 32'd1);
        repeat (3) step();
        chk("noop_no_done", 32'(tr_done[3:0]), 32'd0);
        ifc.sel = 2'd3; ifc.sel_vld = 1'b1;
        step();
        ifc.sel_vld = 1'b0;
        step_until_done(30);
        chk("map3_cur_sel", 32'(cur_sel), 32'd0);

        // move to ch1, then request ch0 in a first high cycle and hold a second request
        ifc.sel = 2'd1; ifc.sel_vld = 1'b1;
        step();
        ifc.sel_vld = 1'b0;
        step_until_done(30);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = clk_en;
        end
        chk("ch1_first_high", 32'(seen), 32'd1);
        ifc.sel = 2'd0; ifc.sel_vld = 1'b1;
        step();
        ifc.sel = 2'd2;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = sw_done;
        end
        ifc.sel_vld = 1'b0;
        chk("sw10_done", 32'(seen), 32'd1);
        chk("sw10_clk_out_trace", 32'(tr_out[5:0]), 32'b100001);
        chk("sw10_cur_sel", 32'(cur_sel), 32'd0);
        repeat (4) step();

        // divider field change takes effect at the next phase start
        ifc.sel = 2'd1; ifc.sel_vld = 1'b1;
        step();
        ifc.sel_vld = 1'b0;
        step_until_done(30);
        div_cfg = 12'h341;
        repeat (10) step();
        chk("cfg4_clk_out_trace", 32'(tr_out[9:0]), 32'b1000011110);
        div_cfg = 12'h301;
        repeat (12) step();

        // reset during GAP discards the pending switch
        ifc.sel = 2'd2; ifc.sel_vld = 1'b1;
        step();
        ifc.sel_vld = 1'b0;
        for (int i = 0; i < 20 && !m_gap; i++) step();
        chk("gap_reached", 32'(m_gap), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_cur_sel", 32'(cur_sel), 32'd0);
        chk("rst_sel_rdy", 32'(ifc.sel_rdy), 32'd1);
        step(); step();
        rst_n = 1'b1;
        repeat (8) step();
        chk("post_rst_no_done", 32'(tr_done[7:0]), 32'd0);
        chk("post_rst_clk_out", 32'(tr_out[3:0]), 32'b1010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clk_div_switch.md
CLK_DIV_SWITCH -- requirements
Module: clk_div_switch

Interface
REQ-001 Parameter CLK_NUM, default 3, number of selectable divided-clock channels; SHALL be >= 2.
REQ-002 Parameter CNT_W, default 4, width of each per-channel half-period field.
REQ-003 Parameter GAP_CYC, default 2, low-gap length in clk cycles inserted at each switch; SHALL be >= 1.
REQ-004 clk  input  1  single clock; every register is clocked on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 div_cfg  input  CLK_NUM*CNT_W  packed half-period per channel; field k is bits [k*CNT_W +: CNT_W].
REQ-007 sel  input  $clog2(CLK_NUM)  requested channel.
REQ-008 sel_vld  input  1  switch request valid.
REQ-009 sel_rdy  output  1  request can be accepted.
REQ-010 clk_out  output  1  registered divided clock, glitch-free.
REQ-011 clk_en  output  1  one-cycle pulse, high in the first clk cycle of each clk_out high phase.
REQ-012 cur_sel  output  $clog2(CLK_NUM)  channel currently driving clk_out.
REQ-013 sw_done  output  1  one-cycle pulse when a switch completes.

Function
REQ-014 Half-period H = div_cfg field of the channel; a field value of 0 SHALL be treated as 1.
REQ-015 H SHALL be latched into h_cur at the start of every phase; div_cfg changes take effect only at the next phase start.
REQ-016 Each phase lasts exactly h_cur clk cycles: clk_out high for h_cur, then low for h_cur.
REQ-017 States: RUN (normal toggling), WAIT (request pending, toggling continues), GAP (clk_out held low).
REQ-018 Handshake: a request is accepted on a clk edge where sel_vld=1 and sel_rdy=1; sel_rdy=1 only in RUN.
REQ-019 An accepted sel >= CLK_NUM SHALL be mapped to channel 0.
REQ-020 An accepted (mapped) sel equal to cur_sel is a no-op: state remains RUN, sel_rdy stays 1, no sw_done.
REQ-021 An accepted sel different from cur_sel is stored in pend_sel; state goes RUN->WAIT; sel_rdy drops the next cycle.
REQ-022 In WAIT, if clk_out is currently high, the high phase and the following low phase complete normally; the switch point is the end of a low phase.
REQ-023 At the end of a low phase in WAIT, clk_out SHALL NOT rise; state goes WAIT->GAP with clk_out low.
REQ-024 GAP lasts exactly GAP_CYC clk cycles, then: cur_sel<=pend_sel, h_cur<=H of the new channel, clk_out rises, clk_en=1, sw_done=1, state GAP->RUN, sel_rdy=1.
REQ-025 Therefore the low time seen at a switch is h_old + GAP_CYC cycles; no high pulse shorter than min(h_old, h_new) ever occurs.
REQ-026 sel_vld and sel in WAIT/GAP SHALL be ignored; the pending request SHALL NOT be altered.
REQ-027 A request accepted in the same cycle a high phase starts SHALL be handled per REQ-022 (current high phase is not shortened).
REQ-028 clk_en and sw_done SHALL be registered, so no combinational path from any input to any output.

Reset
REQ-029 While rst_n=0: clk_out=0, clk_en=0, sw_done=0, cur_sel=0, sel_rdy=1, state RUN, low phase, phase counter 0, gap counter 0, pend_sel=0.
REQ-030 After reset release, h_cur is loaded from channel 0 and the first clk_out rise occurs after h_cur clk edges of low phase.
REQ-031 Reset asserted mid-WAIT or mid-GAP SHALL discard the pending request and immediately force the REQ-029 values.

Verification
REQ-032 CLK_NUM=3, CNT_W=4, GAP_CYC=2, fields {ch0=1, ch1=2, ch2=3}; release reset, no requests -> clk_out period 2 cycles, 50% duty, clk_en every 2 cycles, cur_sel=0.
REQ-033 Running ch0, request sel=2 -> sel_rdy low the next cycle; after the current low phase, clk_out stays low 1+2=3 cycles, then high 3/low 3; cur_sel=2; sw_done and clk_en pulse together on the first high cycle.
REQ-034 Running ch2, request sel=2 -> no-op: sel_rdy stays 1, no sw_done, clk_out unchanged; request sel=3 -> mapped to ch0, switch per REQ-024.
REQ-035 Running ch1, request sel=0 accepted on the first high cycle, then sel_vld=1 with sel=2 held through WAIT/GAP -> high 2, low 2, gap 2, then ch0 toggling; second request ignored; cur_sel=0.
REQ-036 Change ch1 field from 2 to 4 mid-high-phase while running ch1 -> current phase ends after 2 cycles; the next phase lasts 4; field 0 written -> phases of 1.
REQ-037 Assert rst_n=0 during GAP -> clk_out=0, cur_sel=0, sel_rdy=1 immediately; after release, ch0 toggling resumes per REQ-030 with no sw_done.
